// File: rtl/uart_fifo_port.sv
// CPU-bus UART register block: TX/RX FIFOs between the 65C02 data bus and the
// uart_tx/uart_rx serializers, with sticky overflow flags, interrupt enables
// and an RX level readout.
module uart_fifo_port #(
   parameter int TX_DEPTH_LOG2 = 4,
   parameter int RX_DEPTH_LOG2 = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cs,
   input  logic       we,
   input  logic [1:0] addr,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       irq,
   output logic [7:0] tx_data,
   output logic       tx_load,
   input  logic       tx_ready,
   input  logic [7:0] rx_data,
   input  logic       rx_ready,
   output logic       rx_read
);
   localparam int TX_DEPTH = 1 << TX_DEPTH_LOG2;
   localparam int RX_DEPTH = 1 << RX_DEPTH_LOG2;
   localparam logic [TX_DEPTH_LOG2:0]   TX_FULL_CNT = (TX_DEPTH_LOG2 + 1)'(TX_DEPTH);
   localparam logic [RX_DEPTH_LOG2:0]   RX_FULL_CNT = (RX_DEPTH_LOG2 + 1)'(RX_DEPTH);
   localparam logic [TX_DEPTH_LOG2:0]   TX_CNT_ONE  = (TX_DEPTH_LOG2 + 1)'(1);
   localparam logic [RX_DEPTH_LOG2:0]   RX_CNT_ONE  = (RX_DEPTH_LOG2 + 1)'(1);
   localparam logic [TX_DEPTH_LOG2-1:0] TX_PTR_ONE  = (TX_DEPTH_LOG2)'(1);
   localparam logic [RX_DEPTH_LOG2-1:0] RX_PTR_ONE  = (RX_DEPTH_LOG2)'(1);

   // storage
   logic [7:0] tx_mem [TX_DEPTH];
   logic [7:0] rx_mem [RX_DEPTH];

   // FIFO bookkeeping
   logic [TX_DEPTH_LOG2-1:0] tx_wr_ptr_reg, tx_rd_ptr_reg;
   logic [TX_DEPTH_LOG2:0]   tx_count_reg;
   logic [RX_DEPTH_LOG2-1:0] rx_wr_ptr_reg, rx_rd_ptr_reg;
   logic [RX_DEPTH_LOG2:0]   rx_count_reg;

   // control, flags, engines, outputs
   logic [1:0] ctrl_reg;
   logic       tx_ovr_reg, rx_ovr_reg;
   logic       tx_hold_reg, rx_hold_reg;
   logic       tx_load_reg, rx_read_reg;
   logic [7:0] tx_data_reg;
   logic [7:0] dout_reg;
   logic       irq_reg;

   // decoded events
   logic       cpu_wr, cpu_rd;
   logic       tx_empty, tx_full, rx_nonempty, rx_full, tx_idle;
   logic       tx_push_req, tx_push, tx_pop, tx_ovr_set;
   logic       rx_fill, rx_push, rx_pop, rx_ovr_set;
   logic       flag_clr;
   logic [7:0] status, rx_level, rd_data;

   assign cpu_wr      = cs & we;
   assign cpu_rd      = cs & ~we;
   assign tx_empty    = (tx_count_reg == '0);
   assign tx_full     = (tx_count_reg == TX_FULL_CNT);
   assign rx_nonempty = (rx_count_reg != '0);
   assign rx_full     = (rx_count_reg == RX_FULL_CNT);
   assign tx_idle     = tx_empty & tx_ready & ~tx_load_reg;

   // the drain engine waits one cycle after each load so tx_ready can fall
   assign tx_pop      = tx_ready & ~tx_empty & ~tx_hold_reg;
   assign tx_push_req = cpu_wr & (addr == 2'd0);
   assign tx_push     = tx_push_req & (~tx_full | tx_pop);
   assign tx_ovr_set  = tx_push_req & ~tx_push;

   // the fill engine always acknowledges the byte, even if it must drop it
   assign rx_pop      = cpu_rd & (addr == 2'd0) & rx_nonempty;
   assign rx_fill     = rx_ready & ~rx_hold_reg;
   assign rx_push     = rx_fill & (~rx_full | rx_pop);
   assign rx_ovr_set  = rx_fill & ~rx_push;

   assign flag_clr    = cpu_wr & (addr == 2'd1);

   assign status = {1'b0, irq_reg, tx_ovr_reg, rx_ovr_reg,
                    rx_full, rx_nonempty, tx_idle, tx_full};

   // RX level is clipped only when the count can exceed one byte
   generate
      if (RX_DEPTH_LOG2 >= 8) begin : g_level_clip
         assign rx_level = (rx_count_reg > (RX_DEPTH_LOG2 + 1)'(255)) ? 8'hFF : rx_count_reg[7:0];
      end else begin : g_level_ext
         assign rx_level = 8'(rx_count_reg);
      end
   endgenerate

   // CPU read mux; an empty RX pop returns zero
   always_comb begin
      rd_data = 8'h00;
      case (addr)
         2'd0:    if (rx_nonempty) rd_data = rx_mem[rx_rd_ptr_reg];
         2'd1:    rd_data = status;
         2'd2:    rd_data = {6'b0, ctrl_reg};
         default: rd_data = rx_level;
      endcase
   end

   // TX storage write port
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wr_ptr_reg] <= din;
   end

   // TX pointers and occupancy
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_wr_ptr_reg <= '0;
         tx_rd_ptr_reg <= '0;
         tx_count_reg  <= '0;
      end else begin
         if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + TX_PTR_ONE;
         if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + TX_PTR_ONE;
         if (tx_push & ~tx_pop)      tx_count_reg <= tx_count_reg + TX_CNT_ONE;
         else if (~tx_push & tx_pop) tx_count_reg <= tx_count_reg - TX_CNT_ONE;
      end
   end

   // drain engine: load strobe, holdoff and the byte held for uart_tx
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_load_reg <= 1'b0;
         tx_hold_reg <= 1'b0;
         tx_data_reg <= 8'h00;
      end else begin
         tx_load_reg <= tx_pop;
         tx_hold_reg <= tx_pop;
         if (tx_pop) tx_data_reg <= tx_mem[tx_rd_ptr_reg];
      end
   end

   // RX storage write port
   always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wr_ptr_reg] <= rx_data;
   end

   // RX pointers and occupancy
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_wr_ptr_reg <= '0;
         rx_rd_ptr_reg <= '0;
         rx_count_reg  <= '0;
      end else begin
         if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + RX_PTR_ONE;
         if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + RX_PTR_ONE;
         if (rx_push & ~rx_pop)      rx_count_reg <= rx_count_reg + RX_CNT_ONE;
         else if (~rx_push & rx_pop) rx_count_reg <= rx_count_reg - RX_CNT_ONE;
      end
   end

   // fill engine: read strobe and holdoff while uart_rx drops rx_ready
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_read_reg <= 1'b0;
         rx_hold_reg <= 1'b0;
      end else begin
         rx_read_reg <= rx_fill;
         rx_hold_reg <= rx_fill;
      end
   end

   // sticky overflow flags; a new overflow wins over a same-cycle clear
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_ovr_reg <= 1'b0;
         rx_ovr_reg <= 1'b0;
      end else begin
         tx_ovr_reg <= (tx_ovr_reg & ~flag_clr) | tx_ovr_set;
         rx_ovr_reg <= (rx_ovr_reg & ~flag_clr) | rx_ovr_set;
      end
   end

   // interrupt enable register
   always_ff @(posedge clk) begin
      if (reset)                        ctrl_reg <= 2'b00;
      else if (cpu_wr && addr == 2'd2)  ctrl_reg <= din[1:0];
   end

   // registered read data, zero whenever no read is in progress
   always_ff @(posedge clk) begin
      if (reset)       dout_reg <= 8'h00;
      else if (cpu_rd) dout_reg <= rd_data;
      else             dout_reg <= 8'h00;
   end

   // registered interrupt request
   always_ff @(posedge clk) begin
      if (reset) irq_reg <= 1'b0;
      else       irq_reg <= (ctrl_reg[0] & rx_nonempty) | (ctrl_reg[1] & tx_empty);
   end

   assign dout    = dout_reg;
   assign irq     = irq_reg;
   assign tx_data = tx_data_reg;
   assign tx_load = tx_load_reg;
   assign rx_read = rx_read_reg;

endmodule

// File: tb/tb_uart_fifo_port.sv
// Self-checking bench for uart_fifo_port: directed scenarios followed by a
// randomized run, all checked against a queue-based behavioural model.
module tb_uart_fifo_port;
   localparam int TXD = 16;
   localparam int RXD = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cs = 1'b0, we = 1'b0;
   logic [1:0] addr = 2'd0;
   logic [7:0] din = 8'h00;
   logic [7:0] dout, tx_data;
   logic       irq, tx_load, rx_read;
   logic       tx_ready = 1'b0, rx_ready = 1'b0;
   logic [7:0] rx_data = 8'h00;

   int total = 0;
   int bad = 0;

   // behavioural model state
   logic [7:0] m_txq[$];
   logic [7:0] m_rxq[$];
   logic       m_txovr = 1'b0, m_rxovr = 1'b0;
   logic [1:0] m_ctrl = 2'b00;
   logic       m_tx_hold = 1'b0, m_rx_hold = 1'b0;
   logic       m_tx_load = 1'b0, m_rx_read = 1'b0, m_irq = 1'b0;
   logic [7:0] m_tx_data = 8'h00, m_dout = 8'h00;

   // peripheral environment
   bit         tx_en = 1'b0;
   bit         rand_busy = 1'b0;
   int         tx_busy = 0;
   int         busy_len = 10;
   logic [7:0] rx_src[$];
   logic [7:0] load_log[$];
   int         load_cyc[$];
   int         cyc_no = 0;
   int         rd_pulses = 0;

   uart_fifo_port #(.TX_DEPTH_LOG2(4), .RX_DEPTH_LOG2(4)) dut (
      .clk(clk), .reset(reset), .cs(cs), .we(we), .addr(addr), .din(din),
      .dout(dout), .irq(irq), .tx_data(tx_data), .tx_load(tx_load),
      .tx_ready(tx_ready), .rx_data(rx_data), .rx_ready(rx_ready), .rx_read(rx_read)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // one clock of the register-block rules, applied to queues
   task automatic model_update();
      int tn, rn;
      logic [7:0] st, nd, junk;
      logic tpop, rpop, fill, treq;
      tn = m_txq.size();
      rn = m_rxq.size();
      if (reset) begin
         m_txq.delete(); m_rxq.delete();
         m_txovr = 0; m_rxovr = 0; m_ctrl = 2'b00;
         m_tx_hold = 0; m_rx_hold = 0; m_tx_load = 0; m_rx_read = 0;
         m_tx_data = 8'h00; m_dout = 8'h00; m_irq = 0;
         return;
      end
      st = {1'b0, m_irq, m_txovr, m_rxovr, rn == RXD, rn > 0,
            (tn == 0) && tx_ready && !m_tx_load, tn == TXD};
      nd = 8'h00;
      if (cs && !we) begin
         case (addr)
            2'd0:    nd = (rn > 0) ? m_rxq[0] : 8'h00;
            2'd1:    nd = st;
            2'd2:    nd = {6'b0, m_ctrl};
            default: nd = 8'(rn);
         endcase
      end
      tpop = tx_ready && (tn > 0) && !m_tx_hold;
      rpop = cs && !we && (addr == 2'd0) && (rn > 0);
      fill = rx_ready && !m_rx_hold;
      treq = cs && we && (addr == 2'd0);
      m_irq = (m_ctrl[0] && rn > 0) || (m_ctrl[1] && tn == 0);
      if (cs && we && addr == 2'd1) begin m_txovr = 0; m_rxovr = 0; end
      if (tpop) m_tx_data = m_txq.pop_front();
      if (treq) begin
         if (tn < TXD || tpop) m_txq.push_back(din);
         else m_txovr = 1;
      end
      if (rpop) junk = m_rxq.pop_front();
      if (fill) begin
         if (rn < RXD || rpop) m_rxq.push_back(rx_data);
         else m_rxovr = 1;
      end
      if (cs && we && addr == 2'd2) m_ctrl = din[1:0];
      m_tx_load = tpop; m_tx_hold = tpop;
      m_rx_read = fill; m_rx_hold = fill;
      m_dout = nd;
   endtask

   // drive one cycle, advance the model, react like the serializers, compare
   task automatic cyc(input logic c, input logic w, input logic [1:0] a,
                      input logic [7:0] d, input logic r);
      logic p_load, p_read;
      cs = c; we = w; addr = a; din = d; reset = r;
      tx_ready = tx_en && (tx_busy == 0);
      if (!rx_ready && rx_src.size() > 0) begin
         rx_ready = 1'b1;
         rx_data = rx_src.pop_front();
      end
      p_load = m_tx_load;
      p_read = m_rx_read;
      @(posedge clk);
      model_update();
      @(negedge clk);
      if (p_read) rx_ready = 1'b0;
      if (p_load) tx_busy = rand_busy ? int'($urandom_range(1, 4)) : busy_len;
      else if (tx_busy > 0) tx_busy--;
      cyc_no++;
      chk("dout", 32'(dout), 32'(m_dout));
      chk("irq", 32'(irq), 32'(m_irq));
      chk("tx_load", 32'(tx_load), 32'(m_tx_load));
      chk("tx_data", 32'(tx_data), 32'(m_tx_data));
      chk("rx_read", 32'(rx_read), 32'(m_rx_read));
      if (tx_load === 1'b1) begin load_log.push_back(tx_data); load_cyc.push_back(cyc_no); end
      if (rx_read === 1'b1) rd_pulses++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      cyc(1'b1, 1'b1, a, d, 1'b0);
   endtask

   task automatic rd(input logic [1:0] a);
      cyc(1'b1, 1'b0, a, 8'h00, 1'b0);
   endtask

   initial begin
      logic c, w, r;
      logic [1:0] a;
      logic [7:0] d;

      // reset state
      cyc(1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
      cyc(1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
      chk("rst_dout", 32'(dout), 32'h00);
      chk("rst_irq", 32'(irq), 32'h0);
      chk("rst_tx_load", 32'(tx_load), 32'h0);
      chk("rst_rx_read", 32'(rx_read), 32'h0);
      rd(2'd1);
      chk("rst_status", 32'(dout), 32'h00);

      // three bytes out through a slow transmitter
      tx_en = 1'b1; busy_len = 10; load_log.delete(); load_cyc.delete();
      wr(2'd0, 8'h41); wr(2'd0, 8'h42); wr(2'd0, 8'h43);
      idle(45);
      chk("t1_loads", 32'(load_log.size()), 32'd3);
      if (load_log.size() == 3) begin
         chk("t1_byte0", 32'(load_log[0]), 32'h41);
         chk("t1_byte1", 32'(load_log[1]), 32'h42);
         chk("t1_byte2", 32'(load_log[2]), 32'h43);
         chk("t1_gap", 32'((load_cyc[1] - load_cyc[0] >= 2) && (load_cyc[2] - load_cyc[1] >= 2)), 32'd1);
      end
      rd(2'd1);
      chk("t1_tx_idle", 32'(dout[1]), 32'd1);

      // TX overflow with a stalled transmitter
      tx_en = 1'b0;
      for (int i = 0; i < 17; i++) wr(2'd0, 8'(i));
      rd(2'd1);
      chk("t2_tx_full", 32'(dout[0]), 32'd1);
      chk("t2_txovr", 32'(dout[5]), 32'd1);
      wr(2'd1, 8'h00);
      rd(2'd1);
      chk("t2_txovr_clr", 32'(dout[5]), 32'd0);
      load_log.delete(); tx_en = 1'b1; busy_len = 1;
      idle(70);
      chk("t2_drained", 32'(load_log.size()), 32'd16);
      if (load_log.size() == 16) begin
         chk("t2_first", 32'(load_log[0]), 32'h00);
         chk("t2_last", 32'(load_log[15]), 32'h0F);
      end

      // three received bytes read back in order
      rx_src.push_back(8'h10); rx_src.push_back(8'h20); rx_src.push_back(8'h30);
      idle(12);
      rd(2'd3); chk("t3_level", 32'(dout), 32'd3);
      rd(2'd0); chk("t3_rd0", 32'(dout), 32'h10);
      rd(2'd0); chk("t3_rd1", 32'(dout), 32'h20);
      rd(2'd0); chk("t3_rd2", 32'(dout), 32'h30);
      rd(2'd0); chk("t3_rd_empty", 32'(dout), 32'h00);
      idle(1);  chk("t3_dout_idle", 32'(dout), 32'h00);

      // RX overflow without CPU reads
      rd_pulses = 0;
      for (int i = 0; i < 17; i++) rx_src.push_back(8'(8'h80 + i));
      idle(45);
      chk("t4_rx_reads", 32'(rd_pulses), 32'd17);
      rd(2'd1);
      chk("t4_rx_full", 32'(dout[3]), 32'd1);
      chk("t4_rxovr", 32'(dout[4]), 32'd1);
      rd(2'd3); chk("t4_level", 32'(dout), 32'd16);
      rd(2'd0); chk("t4_first", 32'(dout), 32'h80);
      for (int i = 0; i < 14; i++) rd(2'd0);
      rd(2'd0); chk("t4_last", 32'(dout), 32'h8F);
      wr(2'd1, 8'hFF);
      rd(2'd1);
      chk("t4_rxovr_clr", 32'(dout[4]), 32'd0);
      chk("t4_rx_empty", 32'(dout[2]), 32'd0);

      // interrupt timing
      wr(2'd2, 8'h01);
      rx_src.push_back(8'h55);
      idle(1); chk("t5_irq_push", 32'(irq), 32'd0);
      idle(1); chk("t5_irq_rise", 32'(irq), 32'd1);
      idle(2); chk("t5_irq_hold", 32'(irq), 32'd1);
      rd(2'd0);
      chk("t5_data", 32'(dout), 32'h55);
      chk("t5_irq_rd", 32'(irq), 32'd1);
      idle(1); chk("t5_irq_fall", 32'(irq), 32'd0);
      wr(2'd2, 8'h02);
      idle(1); chk("t5_irq_txie", 32'(irq), 32'd1);

      // reset with bytes queued in both directions
      wr(2'd2, 8'h03);
      tx_en = 1'b0;
      for (int i = 0; i < 5; i++) wr(2'd0, 8'(8'hA0 + i));
      for (int i = 0; i < 5; i++) rx_src.push_back(8'(8'hC0 + i));
      idle(15);
      rd(2'd3); chk("t6_level", 32'(dout), 32'd5);
      chk("t6_irq_pre", 32'(irq), 32'd1);
      cyc(1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
      chk("t6_dout", 32'(dout), 32'h00);
      chk("t6_irq", 32'(irq), 32'd0);
      chk("t6_tx_load", 32'(tx_load), 32'd0);
      chk("t6_rx_read", 32'(rx_read), 32'd0);
      rd(2'd3); chk("t6_level_clr", 32'(dout), 32'd0);
      rd(2'd1); chk("t6_status", 32'(dout), 32'h00);
      rd(2'd2); chk("t6_ctrl", 32'(dout), 32'h00);
      tx_en = 1'b1; load_log.delete(); rd_pulses = 0;
      idle(10);
      chk("t6_no_loads", 32'(load_log.size()), 32'd0);
      chk("t6_no_reads", 32'(rd_pulses), 32'd0);

      // randomized traffic against the model
      rand_busy = 1'b1;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 2) == 0 && rx_src.size() < 2) rx_src.push_back(8'($urandom));
         if ($urandom_range(0, 49) == 0) tx_en = !tx_en;
         r = ($urandom_range(0, 199) == 0);
         c = 1'($urandom_range(0, 1));
         w = 1'($urandom_range(0, 1));
         a = 2'($urandom_range(0, 3));
         d = 8'($urandom);
         cyc(c, w, a, d, r);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/uart_fifo_port.md
Name: uart_fifo_port

Overview:
- CPU-bus UART register block. It replaces the ad-hoc UART data/status glue in the 6502 top level.
- Adds parametrised TX and RX FIFOs, sticky error flags, an interrupt-enable register and an RX level readout.
- Sits between the 65C02 data bus and the existing uart_tx/uart_rx serializers. It drives their load/read strobes and buffers bytes in both directions.

Parameters:
- TX_DEPTH_LOG2, 4, log2 of TX FIFO depth (16 entries).
- RX_DEPTH_LOG2, 4, log2 of RX FIFO depth (16 entries).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- cs  in  1  block select, decoded from AB by the top level
- we  in  1  CPU write enable
- addr  in  2  register offset (AB[1:0])
- din  in  8  CPU write data (DO)
- dout  out  8  registered read data, muxed onto DI
- irq  out  1  interrupt request, active-high
- tx_data  out  8  byte to uart_tx.din
- tx_load  out  1  one-cycle load strobe to uart_tx
- tx_ready  in  1  uart_tx idle
- rx_data  in  8  uart_rx.dout
- rx_ready  in  1  uart_rx holds an unread byte
- rx_read  out  1  one-cycle read strobe to uart_rx

Behaviour:
- Reset:
  - FIFO pointers and counts = 0; ctrl = 0; RXOVR = TXOVR = 0.
  - dout = 0x00; tx_load = 0; rx_read = 0; irq = 0; holdoff flags cleared.
  - Reset mid-transfer discards all buffered bytes.
- Register map (cs=1):
  - Offset 0, write: push din to TX FIFO.
  - Offset 0, read: pop RX FIFO head.
  - Offset 1, read: status {0, irq, TXOVR, RXOVR, rx_full, rx_nonempty, tx_idle, tx_full}.
  - Offset 1, write: any value clears RXOVR and TXOVR.
  - Offset 2: ctrl register, R/W; bit0 = RXIE, bit1 = TXIE, other bits read 0.
  - Offset 3, read: RX level, zero-extended or clipped to 8 bits. Writes are ignored.
- Read latency: dout is registered on the clock edge where cs & ~we is sampled, so data is valid the following cycle, matching the CPU DI timing. dout = 0x00 in any cycle after cs=0.
- RX pop: happens in the same cycle as the offset-0 read strobe. dout gets the head byte.
- Empty RX pop: dout = 0x00, pointers unchanged, no flag set.
- TX push:
  - Accepted if not full, or if the drain engine pops in the same cycle.
  - Otherwise the byte is dropped and TXOVR is set (sticky).
- TX drain engine:
  - Condition: tx_ready & TX FIFO nonempty & ~tx_hold.
  - Action: tx_data = head, tx_load pulses for 1 cycle, pop, tx_hold = 1 for the next cycle (lets tx_ready fall).
  - tx_data is held stable until the next load.
- RX fill engine:
  - Condition: rx_ready & ~rx_hold.
  - Action: rx_read pulses for 1 cycle, rx_hold = 1 for the next cycle.
  - If the RX FIFO is not full (or a CPU pop occurs the same cycle), push rx_data. Otherwise discard the byte and set RXOVR.
- Simultaneous events:
  - RX push and CPU pop in the same cycle: both occur, count unchanged.
  - TX push and drain pop in the same cycle: both occur.
  - Status write clearing a flag while a new overflow occurs in the same cycle: the flag stays set.
- Flag definitions:
  - tx_idle = TX FIFO empty & tx_ready & ~tx_load.
  - tx_full = count == 2^TX_DEPTH_LOG2.
  - Counts are DEPTH_LOG2+1 bits wide; pointers wrap modulo depth.
- irq is registered: (RXIE & rx_nonempty) | (TXIE & TX FIFO empty). It deasserts one cycle after the cause clears.

Test Plan:
- Write 0x41, 0x42, 0x43 to offset 0 with tx_ready=1, and tx_ready low for 10 cycles after each load:
  - Expect three tx_load pulses, tx_data = 0x41, 0x42, 0x43 in order, separated by at least 2 cycles.
  - tx_idle = 1 at the end.
- Hold tx_ready=0 and write 17 bytes:
  - First 16 accepted, status tx_full=1, TXOVR=1.
  - After a write to offset 1, TXOVR=0.
- Present 3 rx_ready bytes 0x10, 0x20, 0x30, each dropping rx_ready after rx_read:
  - Offset 3 reads 3.
  - Three offset-0 reads return 0x10, 0x20, 0x30 one cycle after each strobe.
  - A fourth read returns 0x00.
- Present 17 RX bytes with no CPU reads:
  - rx_full=1, RXOVR=1, level 16.
  - The 17th byte is discarded and rx_read still pulses 17 times.
- Set ctrl=0x01, then inject one RX byte:
  - irq rises 2 cycles after the push.
  - irq falls the cycle after the data read empties the FIFO.
  - With ctrl=0x02 and the TX FIFO empty, irq=1.
- Assert reset with 5 bytes queued in each FIFO:
  - Next cycle: levels 0, dout=0x00, irq=0, no tx_load or rx_read pulses.
